// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling points.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RST_VAL sets the value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with optional parity check.
// Emits a one-cycle rx_done_tick with dout and error flags per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(START_MID);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  uart_state_t     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            perr_q, perr_d;
  logic            armed_q, armed_d;
  logic [DBIT-1:0] dout_d;
  logic            done_d;
  logic            pe_d;
  logic            fe_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      p_q          <= 1'b0;
      perr_q       <= 1'b0;
      armed_q      <= 1'b1;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      p_q          <= p_d;
      perr_q       <= perr_d;
      armed_q      <= armed_d;
      dout         <= dout_d;
      rx_done_tick <= done_d;
      parity_err   <= pe_d;
      frame_err    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    perr_d  = perr_q;
    armed_d = armed_q;
    dout_d  = dout;
    done_d  = 1'b0;
    pe_d    = parity_err;
    fe_d    = frame_err;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
              p_d     = (PARITY_ODD != 0);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            p_d = p_q ^ rx_s;
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            perr_d  = p_q ^ rx_s;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            pe_d    = (PARITY_EN != 0) ? perr_q : 1'b0;
            fe_d    = ~rx_s;
            // a low stop bit disarms until the line idles high again
            if (!rx_s) armed_d = 1'b0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx (8N1 and 8E1 instances).
// Frames are built bit by bit; expectations come from a frame-level model.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_T    = 16;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_a   = 1'b1;
  logic       rx_b   = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       done_a, done_b;
  logic       pe_a, pe_b;
  logic       fe_a, fe_b;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_rx u_a (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx_a),
    .s_tick      (s_tick),
    .dout        (dout_a),
    .rx_done_tick(done_a),
    .parity_err  (pe_a),
    .frame_err   (fe_a)
  );

  uart_rx #(
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx_b),
    .s_tick      (s_tick),
    .dout        (dout_b),
    .rx_done_tick(done_b),
    .parity_err  (pe_b),
    .frame_err   (fe_b)
  );

  int tcnt = 0;
  always @(negedge clk) begin
    tcnt   = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    s_tick = (tcnt == 0);
  end

  longint     cyc = 0;
  int         done_cnt [2];
  int         wide     [2];
  logic       prev_dn  [2];
  logic [7:0] cap_dout [2];
  logic [7:0] prv_dout [2];
  logic       cap_pe   [2];
  logic       cap_fe   [2];
  longint     last_cyc [2];
  longint     prev_cyc [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      wide[i]     = 0;
      prev_dn[i]  = 1'b0;
      cap_dout[i] = '0;
      prv_dout[i] = '0;
      cap_pe[i]   = 1'b0;
      cap_fe[i]   = 1'b0;
      last_cyc[i] = 0;
      prev_cyc[i] = 0;
    end
  end

  task automatic mon(input int i, input logic d, input logic [7:0] v,
                     input logic pe, input logic fe);
    if (d === 1'b1) begin
      if (prev_dn[i]) wide[i]++;
      done_cnt[i]++;
      prv_dout[i] = cap_dout[i];
      cap_dout[i] = v;
      cap_pe[i]   = pe;
      cap_fe[i]   = fe;
      prev_cyc[i] = last_cyc[i];
      last_cyc[i] = cyc;
    end
    prev_dn[i] = (d === 1'b1);
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, done_a, dout_a, pe_a, fe_a);
    mon(1, done_b, dout_b, pe_b, fe_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit use_par,
                      input logic pbit, input logic stopv);
    set_rx(sel, 1'b0);
    wait_ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      wait_ticks(BIT_T);
    end
    if (use_par) begin
      set_rx(sel, pbit);
      wait_ticks(BIT_T);
    end
    set_rx(sel, stopv);
    wait_ticks(BIT_T);
  endtask

  // frame-level model: even/odd parity on the total count of ones
  function automatic logic model_pe(input logic [7:0] d, input bit par_en,
                                    input bit odd, input logic pbit);
    int ones;
    ones = $countones({d, pbit});
    return par_en && ((ones % 2) != (odd ? 1 : 0));
  endfunction

  task automatic check_frame(input string tag, input int sel, input int c0,
                             input logic [7:0] d, input bit par_en,
                             input logic pbit, input logic stopv);
    chk({tag, "/cnt"}, done_cnt[sel], c0 + 1);
    chk({tag, "/dout"}, cap_dout[sel], d);
    chk({tag, "/perr"}, cap_pe[sel], model_pe(d, par_en, 1'b0, pbit));
    chk({tag, "/ferr"}, cap_fe[sel], !stopv);
    chk({tag, "/hold"}, (sel == 0) ? dout_a : dout_b, d);
  endtask

  initial begin
    int         c, cb;
    logic [7:0] d, fc6;
    logic       pb, sv;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/dout_a", dout_a, 0);
    chk("rst/done_a", done_a, 0);
    chk("rst/perr_a", pe_a, 0);
    chk("rst/ferr_a", fe_a, 0);
    chk("rst/dout_b", dout_b, 0);
    reset = 1'b0;
    wait_ticks(4);

    c = done_cnt[0];
    rx_a = 1'b0;
    wait_ticks(4);
    rx_a = 1'b1;
    wait_ticks(24);
    chk("glitch/cnt", done_cnt[0], c);
    chk("glitch/dout", dout_a, 0);

    c = done_cnt[0];
    send(0, 8'h55, 0, 1'b0, 1'b1);
    wait_ticks(2);
    check_frame("f55", 0, c, 8'h55, 0, 1'b0, 1'b1);

    c = done_cnt[1];
    send(1, 8'hA3, 1, 1'b0, 1'b1);
    wait_ticks(2);
    check_frame("a3_p0", 1, c, 8'hA3, 1, 1'b0, 1'b1);
    c = done_cnt[1];
    send(1, 8'hA3, 1, 1'b1, 1'b1);
    wait_ticks(2);
    check_frame("a3_p1", 1, c, 8'hA3, 1, 1'b1, 1'b1);

    c = done_cnt[0];
    send(0, 8'h0F, 0, 1'b0, 1'b0);
    wait_ticks(3 * 10 * BIT_T);
    check_frame("brk", 0, c, 8'h0F, 0, 1'b0, 1'b0);
    rx_a = 1'b1;
    wait_ticks(BIT_T);
    c = done_cnt[0];
    send(0, 8'h3C, 0, 1'b0, 1'b1);
    wait_ticks(2);
    check_frame("after_brk", 0, c, 8'h3C, 0, 1'b0, 1'b1);

    c   = done_cnt[0];
    cb  = done_cnt[1];
    fc6 = 8'hC6;
    rx_a = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx_a = fc6[i];
      wait_ticks(BIT_T);
    end
    rx_a = fc6[4];
    wait_ticks(BIT_T / 2);
    reset = 1'b1;
    rx_a  = 1'b1;
    #2;
    chk("rst_mid/dout_a", dout_a, 0);
    chk("rst_mid/done_a", done_a, 0);
    chk("rst_mid/perr_b", pe_b, 0);
    chk("rst_mid/ferr_a", fe_a, 0);
    chk("rst_mid/dout_b", dout_b, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ticks(2 * BIT_T);
    chk("rst_mid/no_done_a", done_cnt[0], c);
    chk("rst_mid/no_done_b", done_cnt[1], cb);
    send(0, 8'h81, 0, 1'b0, 1'b1);
    wait_ticks(2);
    check_frame("f81", 0, c, 8'h81, 0, 1'b0, 1'b1);

    c = done_cnt[0];
    send(0, 8'h00, 0, 1'b0, 1'b1);
    send(0, 8'hFF, 0, 1'b0, 1'b1);
    wait_ticks(2);
    chk("b2b/cnt", done_cnt[0], c + 2);
    chk("b2b/first", prv_dout[0], 8'h00);
    chk("b2b/second", cap_dout[0], 8'hFF);
    chk("b2b/gap", 32'(last_cyc[0] - prev_cyc[0]), 10 * BIT_T * TICK_DIV);

    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      sv = 1'($urandom_range(0, 1));
      c  = done_cnt[0];
      send(0, d, 0, 1'b0, sv);
      wait_ticks(2);
      check_frame("rnd_a", 0, c, d, 0, 1'b0, sv);
      rx_a = 1'b1;
      wait_ticks(BIT_T);
    end

    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      c  = done_cnt[1];
      send(1, d, 1, pb, 1'b1);
      wait_ticks(2);
      check_frame("rnd_b", 1, c, d, 1, pb, 1'b1);
    end

    chk("width_a", wide[0], 0);
    chk("width_b", wide[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
